dft_scan_responder: RTL and testbench
=====================================

Name: dft_scan_responder

Overview:
- Chain-side responder for one DFT scan chain: the other end of the val_op/op_ack/op_commit/commit_ack/output_strobe handshake issued per chain by the AXI prewrapper controller.
- On each request it acknowledges, unloads the scan chain non-destructively (the chain recirculates, so its state is preserved), and packs the serial bits into 32-bit words, each marked by a strobe.
- It then raises op_commit and holds it until commit_ack.
- One instance is placed per scan chain, up to 16 per design.

Parameters:
- p_sc_len, 64, scan chain length in bits; legal range 1..4096.
- p_word_w, 32, output word width; fixed at 32, matching the prewrapper's 32-bit per-chain data slice.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- val_op  input  1  operation request from the prewrapper (dft_val_op bit).
- op_ack  output  1  one-cycle acknowledge of val_op.
- op_commit  output  1  unload complete; held until commit_ack.
- commit_ack  input  1  prewrapper has consumed the commit.
- output_strobe  output  1  one-cycle pulse; output_data holds a valid word.
- output_data  output  32  packed scan word; LSB is the earliest-shifted bit.
- scan_en  output  1  scan-enable to the chain; high only while shifting.
- scan_in  output  1  serial input to the chain; equals scan_out while scan_en=1, else 0.
- scan_out  input  1  serial output from the chain.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high), applicable at any time including mid-operation:
  - state returns to IDLE;
  - bit counter and word register clear;
  - op_ack, op_commit, output_strobe, scan_en, busy and output_data all go to 0;
  - scan_in=0.
  - No partial word or commit is emitted after reset deasserts.
- States are IDLE, ACK, SHIFT, FLUSH, COMMIT. All outputs are registered except scan_in.
- IDLE:
  - val_op sampled high -> ACK on the next cycle.
- ACK:
  - op_ack=1 for exactly one cycle, then SHIFT.
  - val_op is ignored from ACK until the FSM returns to IDLE. A held or re-pulsed val_op produces no extra ack.
- SHIFT:
  - Lasts exactly p_sc_len cycles; shift cycles are numbered k = 0..p_sc_len-1.
  - scan_en=1 throughout.
  - At the end of cycle k, scan_out is captured into word bit (k mod 32).
  - When k mod 32 = 31 and k is not the last cycle, output_strobe=1 in cycle k+1 and output_data is loaded with the completed word.
  - After cycle k = p_sc_len-1 -> FLUSH.
- FLUSH:
  - One cycle, scan_en=0, output_strobe=1.
  - output_data carries the final word; bits at or above (p_sc_len mod 32) are zero when p_sc_len mod 32 ≠ 0.
  - Next state is COMMIT.
- Word count:
  - ceil(p_sc_len/32) strobes per operation.
  - The strobe of the final word falls in FLUSH. All other strobes fall inside SHIFT.
- output_data between strobes:
  - Holds its last value between strobes.
  - Is not cleared between operations; only reset clears it.
  - The word accumulator clears at entry to SHIFT.
- COMMIT:
  - op_commit=1 from the first COMMIT cycle.
  - When commit_ack is sampled high, op_commit=0 on the next cycle and the FSM goes to IDLE.
  - commit_ack high in the same cycle op_commit first rises is honoured; COMMIT then lasts 1 cycle.
- commit_ack outside COMMIT is ignored.
- val_op high in the same cycle the FSM returns to IDLE is sampled on the following cycle. The minimum turnaround from commit_ack to the next op_ack is 2 cycles.
- Counters:
  - The bit counter is $clog2(p_sc_len+1) bits wide and never wraps within an operation.
  - The word-bit index is 5 bits and wraps 31 -> 0.
- Total latency, from val_op sampled to op_commit rising, is p_sc_len+3 cycles.
- scan_in=scan_out recirculation means that after one operation the chain contents equal their pre-operation contents.

Test Plan:
- p_sc_len=64; chain preloaded so that it shifts out 0x12345678 first (LSB first), then 0xDEADBEEF; pulse val_op:
  - op_ack pulses 1 cycle later;
  - scan_en is high for 64 cycles;
  - strobes with 0x12345678 in shift cycle 32 and 0xDEADBEEF in FLUSH;
  - op_commit rises 67 cycles after val_op is sampled;
  - commit_ack -> op_commit low the next cycle.
- Run the same operation twice back-to-back: identical data on the second run, confirming non-destructive recirculation.
- p_sc_len=40; chain bits all 1:
  - strobe 1 carries 0xFFFFFFFF;
  - strobe 2 (FLUSH) carries 0x000000FF;
  - exactly 2 strobes.
- p_sc_len=1; scan_out=1: single strobe in FLUSH with 0x00000001; scan_en is high for 1 cycle.
- Hold val_op high throughout; delay commit_ack by 10 cycles:
  - a single op_ack;
  - op_commit held for 10 cycles;
  - the next op_ack appears exactly 2 cycles after commit_ack is sampled.
- Assert reset in SHIFT cycle 20, then release:
  - all outputs 0 immediately (asynchronous);
  - no strobe or commit after release;
  - a new val_op runs a full, correct operation.

Source files
------------

// File: rtl/dft_scan_responder.sv
// Chain-side scan responder: acks a request, unloads the chain with recirculation,
// packs serial bits LSB-first into words with strobes, then holds a commit until acked.
module dft_scan_responder #(
    parameter int unsigned p_sc_len = 64,
    parameter int unsigned p_word_w = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                val_op,
    output logic                op_ack,
    output logic                op_commit,
    input  logic                commit_ack,
    output logic                output_strobe,
    output logic [p_word_w-1:0] output_data,
    output logic                scan_en,
    output logic                scan_in,
    input  logic                scan_out,
    output logic                busy
);

    localparam int unsigned CntW = $clog2(p_sc_len + 1);
    localparam int unsigned IdxW = $clog2(p_word_w);
    localparam logic [CntW-1:0] LastBit = CntW'(p_sc_len - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(p_word_w - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAck,
        StShift,
        StFlush,
        StCommit
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [p_word_w-1:0] acc_q, acc_d;
    logic [p_word_w-1:0] data_q, data_d;
    logic [p_word_w-1:0] word_done;

    logic op_ack_q, op_ack_d;
    logic op_commit_q, op_commit_d;
    logic strobe_q, strobe_d;
    logic scan_en_q, scan_en_d;
    logic busy_q, busy_d;

    // Accumulator with this cycle's scan bit merged in; higher bits stay zero
    // because the accumulator is cleared at the start of every word.
    always_comb begin
        word_done        = acc_q;
        word_done[idx_q] = scan_out;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        data_d      = data_q;
        op_ack_d    = 1'b0;
        op_commit_d = 1'b0;
        strobe_d    = 1'b0;
        scan_en_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (val_op) begin
                    state_d  = StAck;
                    op_ack_d = 1'b1;
                end
            end

            StAck: begin
                state_d   = StShift;
                scan_en_d = 1'b1;
                cnt_d     = '0;
                idx_d     = '0;
                acc_d     = '0;
            end

            StShift: begin
                if (cnt_q == LastBit) begin
                    // Final (possibly partial) word is strobed during FLUSH.
                    state_d  = StFlush;
                    strobe_d = 1'b1;
                    data_d   = word_done;
                    acc_d    = '0;
                end else begin
                    scan_en_d = 1'b1;
                    cnt_d     = cnt_q + CntW'(1);
                    idx_d     = idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        strobe_d = 1'b1;
                        data_d   = word_done;
                        acc_d    = '0;
                    end else begin
                        acc_d = word_done;
                    end
                end
            end

            StFlush: begin
                state_d     = StCommit;
                op_commit_d = 1'b1;
            end

            StCommit: begin
                if (commit_ack) begin
                    state_d = StIdle;
                end else begin
                    op_commit_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            op_ack_q    <= 1'b0;
            op_commit_q <= 1'b0;
            strobe_q    <= 1'b0;
            scan_en_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            op_ack_q    <= op_ack_d;
            op_commit_q <= op_commit_d;
            strobe_q    <= strobe_d;
            scan_en_q   <= scan_en_d;
            busy_q      <= busy_d;
        end
    end

    assign op_ack        = op_ack_q;
    assign op_commit     = op_commit_q;
    assign output_strobe = strobe_q;
    assign output_data   = data_q;
    assign scan_en       = scan_en_q;
    assign busy          = busy_q;
    // Recirculate the chain while shifting so its contents survive the unload.
    assign scan_in       = scan_en_q & scan_out;

endmodule

// File: tb/tb_dft_scan_responder.sv
// Bench for dft_scan_responder: three chain lengths (64, 40, 1) driven by behavioural
// scan chains, with expected words and timing derived from the preloaded chain contents.
module tb_dft_scan_responder;

    localparam int L0 = 64;
    localparam int L1 = 40;
    localparam int L2 = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  val_op, commit_ack;
    logic [2:0]  op_ack, op_commit, strobe, scan_en, scan_in, scan_out, busy;
    logic [31:0] data [3];

    logic [2:0]  ld;
    logic [63:0] ld_val [3];
    logic [L0-1:0] ch0;
    logic [L1-1:0] ch1;
    logic [L2-1:0] ch2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dft_scan_responder #(.p_sc_len(L0), .p_word_w(32)) u_dut0 (
        .clk(clk), .reset(reset), .val_op(val_op[0]), .op_ack(op_ack[0]),
        .op_commit(op_commit[0]), .commit_ack(commit_ack[0]), .output_strobe(strobe[0]),
        .output_data(data[0]), .scan_en(scan_en[0]), .scan_in(scan_in[0]),
        .scan_out(scan_out[0]), .busy(busy[0])
    );
    dft_scan_responder #(.p_sc_len(L1), .p_word_w(32)) u_dut1 (
        .clk(clk), .reset(reset), .val_op(val_op[1]), .op_ack(op_ack[1]),
        .op_commit(op_commit[1]), .commit_ack(commit_ack[1]), .output_strobe(strobe[1]),
        .output_data(data[1]), .scan_en(scan_en[1]), .scan_in(scan_in[1]),
        .scan_out(scan_out[1]), .busy(busy[1])
    );
    dft_scan_responder #(.p_sc_len(L2), .p_word_w(32)) u_dut2 (
        .clk(clk), .reset(reset), .val_op(val_op[2]), .op_ack(op_ack[2]),
        .op_commit(op_commit[2]), .commit_ack(commit_ack[2]), .output_strobe(strobe[2]),
        .output_data(data[2]), .scan_en(scan_en[2]), .scan_in(scan_in[2]),
        .scan_out(scan_out[2]), .busy(busy[2])
    );

    // Behavioural scan chains: bit 0 leaves first, scan_in enters at the far end.
    assign scan_out = {ch2[0], ch1[0], ch0[0]};
    always @(posedge clk) begin
        if (ld[0]) ch0 <= ld_val[0][L0-1:0];
        else if (scan_en[0]) ch0 <= {scan_in[0], ch0[L0-1:1]};
        if (ld[1]) ch1 <= ld_val[1][L1-1:0];
        else if (scan_en[1]) ch1 <= {scan_in[1], ch1[L1-1:1]};
        if (ld[2]) ch2 <= ld_val[2][L2-1:0];
        else if (scan_en[2]) ch2 <= scan_in[2];
    end

    // Event monitor, sampled on the falling edge.
    int cyc = 0;
    int en_cnt [3] = '{0, 0, 0};
    int ack_cnt [3] = '{0, 0, 0};
    int cmt_cnt [3] = '{0, 0, 0};
    logic [31:0] sd0 [$], sd1 [$], sd2 [$];
    int st0 [$], st1 [$], st2 [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (scan_en[i] === 1'b1) en_cnt[i]++;
            if (op_ack[i] === 1'b1) ack_cnt[i]++;
            if (op_commit[i] === 1'b1) cmt_cnt[i]++;
        end
        if (strobe[0] === 1'b1) begin sd0.push_back(data[0]); st0.push_back(cyc); end
        if (strobe[1] === 1'b1) begin sd1.push_back(data[1]); st1.push_back(cyc); end
        if (strobe[2] === 1'b1) begin sd2.push_back(data[2]); st2.push_back(cyc); end
    end

    function automatic int nstrb(input int i);
        return (i == 0) ? sd0.size() : (i == 1) ? sd1.size() : sd2.size();
    endfunction

    function automatic logic [31:0] sdata(input int i, input int k);
        return (i == 0) ? sd0[k] : (i == 1) ? sd1[k] : sd2[k];
    endfunction

    function automatic int stime(input int i, input int k);
        return (i == 0) ? st0[k] : (i == 1) ? st1[k] : st2[k];
    endfunction

    // Reference: word w holds chain bits 32w..32w+31, bits past the chain end are zero.
    function automatic logic [31:0] model_word(input logic [63:0] pre, input int len,
                                               input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (32 * w + b < len) r[b] = pre[32 * w + b];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int i, input logic [63:0] v);
        ld_val[i] = v;
        ld[i] = 1'b1;
        step();
        ld[i] = 1'b0;
    endtask

    task automatic chk_quiet(input string tag, input int i);
        chk({tag, " op_ack"}, {31'd0, op_ack[i]}, 32'd0);
        chk({tag, " op_commit"}, {31'd0, op_commit[i]}, 32'd0);
        chk({tag, " strobe"}, {31'd0, strobe[i]}, 32'd0);
        chk({tag, " scan_en"}, {31'd0, scan_en[i]}, 32'd0);
        chk({tag, " scan_in"}, {31'd0, scan_in[i]}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy[i]}, 32'd0);
        chk({tag, " data"}, data[i], 32'd0);
    endtask

    // Entered and left in an IDLE cycle, one time unit after the rising edge.
    task automatic do_op(input int i, input int len, input logic [63:0] pre, input bit hold,
                         input int dly, input string tag);
        int s_n, s_en, s_ack, s_cmt, t_ack, n, nw, we;
        s_n = nstrb(i);
        s_en = en_cnt[i];
        s_ack = ack_cnt[i];
        s_cmt = cmt_cnt[i];
        val_op[i] = 1'b1;
        step();
        chk({tag, " op_ack"}, {31'd0, op_ack[i]}, 32'd1);
        chk({tag, " busy"}, {31'd0, busy[i]}, 32'd1);
        t_ack = cyc + 1;
        if (!hold) val_op[i] = 1'b0;
        n = 0;
        while (op_commit[i] !== 1'b1 && n < len + 8) begin
            step();
            n++;
        end
        chk({tag, " commit_latency"}, n + 1, len + 3);
        nw = (len + 31) / 32;
        chk({tag, " strobe_count"}, nstrb(i) - s_n, nw);
        for (int w = 0; w < nw; w++) begin
            if (s_n + w < nstrb(i)) begin
                we = t_ack + 1 + ((32 * (w + 1) < len) ? 32 * (w + 1) : len);
                chk($sformatf("%s word%0d", tag, w), sdata(i, s_n + w), model_word(pre, len, w));
                chk($sformatf("%s word%0d_cycle", tag, w), stime(i, s_n + w), we);
            end
        end
        chk({tag, " scan_en_cycles"}, en_cnt[i] - s_en, len);
        for (int c = 1; c < dly; c++) step();
        chk({tag, " commit_held"}, {31'd0, op_commit[i]}, 32'd1);
        commit_ack[i] = 1'b1;
        step();
        commit_ack[i] = 1'b0;
        chk({tag, " commit_drop"}, {31'd0, op_commit[i]}, 32'd0);
        chk({tag, " idle_busy"}, {31'd0, busy[i]}, 32'd0);
        chk({tag, " commit_cycles"}, cmt_cnt[i] - s_cmt, dly);
        chk({tag, " ack_count"}, ack_cnt[i] - s_ack, 32'd1);
    endtask

    initial begin
        logic [63:0] r;
        int s_n, s_cmt;
        reset = 1'b1;
        val_op = '0;
        commit_ack = '0;
        ld = '0;
        for (int i = 0; i < 3; i++) ld_val[i] = '0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) chk_quiet($sformatf("reset%0d", i), i);
        reset = 1'b0;
        step();

        // Directed 64-bit chain, run twice to confirm recirculation keeps the data.
        preload(0, 64'hDEADBEEF_12345678);
        do_op(0, L0, 64'hDEADBEEF_12345678, 1'b0, 1, "l64_run1");
        do_op(0, L0, 64'hDEADBEEF_12345678, 1'b0, 3, "l64_run2");

        preload(1, '1);
        do_op(1, L1, '1, 1'b0, 1, "l40_ones");

        preload(2, 64'd1);
        do_op(2, L2, 64'd1, 1'b0, 2, "l1_one");

        // Held request with delayed commit_ack: back-to-back ops, 2-cycle turnaround.
        preload(0, 64'h0F0F_1234_A5A5_5A5A);
        do_op(0, L0, 64'h0F0F_1234_A5A5_5A5A, 1'b1, 10, "hold_a");
        do_op(0, L0, 64'h0F0F_1234_A5A5_5A5A, 1'b1, 10, "hold_b");
        val_op[0] = 1'b0;
        step();

        // Randomized contents on every chain length.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 3; i++) begin
                r = {$urandom, $urandom};
                preload(i, r);
                do_op(i, (i == 0) ? L0 : (i == 1) ? L1 : L2, r, 1'b0,
                      int'($urandom_range(1, 4)), $sformatf("rand%0d_%0d", i, t));
            end
        end

        // Reset in shift cycle 20.
        preload(0, 64'hCAFEF00D_8BADF00D);
        val_op[0] = 1'b1;
        step();
        val_op[0] = 1'b0;
        repeat (21) step();
        chk("rst_mid scan_en_before", {31'd0, scan_en[0]}, 32'd1);
        s_n = nstrb(0);
        s_cmt = cmt_cnt[0];
        #1 reset = 1'b1;
        #1;
        chk_quiet("rst_mid async", 0);
        step();
        reset = 1'b0;
        repeat (80) step();
        chk("rst_mid no_strobe", nstrb(0) - s_n, 32'd0);
        chk("rst_mid no_commit", cmt_cnt[0] - s_cmt, 32'd0);
        chk("rst_mid idle", {31'd0, busy[0]}, 32'd0);
        preload(0, 64'hCAFEF00D_8BADF00D);
        do_op(0, L0, 64'hCAFEF00D_8BADF00D, 1'b0, 1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
